arbitro_rr: RTL and testbench

Parametrised N-channel arbiter between a bank of input FIFOs and a bank of output FIFOs. Each cycle it selects one non-empty input FIFO, either by fixed priority or round-robin, and pops one word. It routes that word to the output FIFO named by the word's destination field. This block is the generalised successor of the 4-channel fixed arbiter. It adds configurable channel count and width, selectable arbitration mode, destination routing and a one-stage registered datapath.

---
 rtl/arbitro_pkg.sv | 19 +
 rtl/arbitro_rr_picker.sv | 37 +++
 rtl/arbitro_rr.sv | 92 +++++++++
 tb/tb_arbitro_rr.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/arbitro_pkg.sv
// rtl/arbitro_pkg.sv - shared constants and width helpers for the arbitro_rr arbiter
package arbitro_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Width of a channel index / destination field; never narrower than one bit.
    function automatic int ch_width(input int n_ch);
        return (clog2(n_ch) < 1) ? 1 : clog2(n_ch);
    endfunction

endpackage

// File: rtl/arbitro_rr_picker.sv
// rtl/arbitro_rr_picker.sv - combinational round-robin picker: rotate by ptr, find first, un-rotate
import arbitro_pkg::*;

module rr_picker #(
    parameter int N_CH = 4,
    parameter int CH_W = ch_width(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic            grant_valid,
    output logic [CH_W-1:0] grant_idx
);

    logic [N_CH-1:0] rot;
    logic [CH_W:0]   idx;
    logic [CH_W:0]   off;

    always_comb begin
        rot = '0;
        idx = '0;
        off = '0;
        // rot[i] is the request of channel (ptr + i) mod N_CH
        for (int i = 0; i < N_CH; i++) begin
            idx = {1'b0, ptr} + (CH_W+1)'(i);
            if (idx >= (CH_W+1)'(N_CH)) idx = idx - (CH_W+1)'(N_CH);
            rot[i] = req[idx[CH_W-1:0]];
        end
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (rot[i]) off = (CH_W+1)'(i);
        end
        idx = {1'b0, ptr} + off;
        if (idx >= (CH_W+1)'(N_CH)) idx = idx - (CH_W+1)'(N_CH);
        grant_idx   = idx[CH_W-1:0];
        grant_valid = |req;
    end

endmodule

// File: rtl/arbitro_rr.sv
// rtl/arbitro_rr.sv - N-channel fixed/round-robin arbiter routing words to output FIFOs by destination field
import arbitro_pkg::*;

module arbitro_rr #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mode,
    input  logic [N_CH-1:0]          empty_in,
    input  logic [N_CH*DATA_W-1:0]   data_in,
    input  logic [N_CH-1:0]          almost_full_out,
    output logic [N_CH-1:0]          pop,
    output logic [N_CH-1:0]          push,
    output logic [DATA_W-1:0]        data_out,
    output logic                     err
);

    localparam int CH_W = ch_width(N_CH);

    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [CH_W-1:0]   pick_ptr;
    logic [CH_W-1:0]   grant_idx;
    logic [CH_W-1:0]   dest;
    logic [N_CH-1:0]   req;
    logic              grant_valid;
    logic              grant;
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] data_q, data_d;
    logic [N_CH-1:0]   push_q, push_d;
    logic              err_q, err_d;

    assign req      = ~empty_in;
    // Fixed priority is round-robin anchored at channel 0; ptr keeps advancing either way.
    assign pick_ptr = (mode == MODE_RR) ? ptr_q : '0;

    rr_picker #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_picker (
        .req         (req),
        .ptr         (pick_ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        grant = grant_valid && !(|almost_full_out) && !reset;
        pop   = '0;
        word  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant_idx == CH_W'(i)) word = data_in[i*DATA_W +: DATA_W];
        end
        if (grant) pop[grant_idx] = 1'b1;

        dest   = word[DATA_W-1 -: CH_W];
        ptr_d  = ptr_q;
        push_d = '0;
        err_d  = 1'b0;
        data_d = data_q;
        if (grant) begin
            ptr_d = (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + CH_W'(1);
            // Out-of-range destinations exist only for non-power-of-two channel counts.
            if (int'(dest) < N_CH) begin
                push_d[dest] = 1'b1;
                data_d       = word;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q  <= '0;
            push_q <= '0;
            err_q  <= 1'b0;
            data_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            push_q <= push_d;
            err_q  <= err_d;
            data_q <= data_d;
        end
    end

    assign push     = push_q;
    assign err      = err_q;
    assign data_out = data_q;

endmodule

// File: tb/tb_arbitro_rr.sv
// tb/tb_arbitro_rr.sv - randomized and directed checks of arbitro_rr against a behavioural model
module tb_arbitro_rr;

    logic        clk;
    logic        rst4, mode4, err4;
    logic [3:0]  emp4, af4, pop4, push4;
    logic [31:0] dat4;
    logic [7:0]  dout4;
    logic        rst3, mode3, err3;
    logic [2:0]  emp3, af3, pop3, push3;
    logic [23:0] dat3;
    logic [7:0]  dout3;

    int n_tests = 0;
    int n_fail  = 0;
    int mptr[2], mpush[2], merr[2], mdata[2];

    arbitro_rr #(.N_CH(4), .DATA_W(8)) u_dut4 (
        .clk(clk), .reset(rst4), .mode(mode4), .empty_in(emp4), .data_in(dat4),
        .almost_full_out(af4), .pop(pop4), .push(push4), .data_out(dout4), .err(err4)
    );

    arbitro_rr #(.N_CH(3), .DATA_W(8)) u_dut3 (
        .clk(clk), .reset(rst3), .mode(mode3), .empty_in(emp3), .data_in(dat3),
        .almost_full_out(af3), .pop(pop3), .push(push3), .data_out(dout3), .err(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compares one DUT with the model, then advances the model to the state after the next edge.
    task automatic model_step(input int d, input int n, input logic r, input logic m,
                              input int emp, input int af, input logic [127:0] din,
                              input logic [31:0] a_pop, input logic [31:0] a_push,
                              input logic [31:0] a_dout, input logic [31:0] a_err);
        int req, g, start, c, w, dest, chw;
        req = ~emp & ((1 << n) - 1);
        chw = (n <= 2) ? 1 : (n <= 4) ? 2 : (n <= 8) ? 3 : 4;
        g = -1;
        if (!r && af == 0 && req != 0) begin
            start = m ? mptr[d] : 0;
            for (int k = 0; k < n; k++) begin
                c = (start + k) % n;
                if (g < 0 && req[c]) g = c;
            end
        end
        chk($sformatf("n%0d pop", n), a_pop, (g >= 0) ? (1 << g) : 0);
        chk($sformatf("n%0d push", n), a_push, mpush[d]);
        chk($sformatf("n%0d err", n), a_err, merr[d]);
        chk($sformatf("n%0d data_out", n), a_dout, mdata[d]);
        if (r) begin
            mptr[d] = 0; mpush[d] = 0; merr[d] = 0; mdata[d] = 0;
        end else if (g >= 0) begin
            mptr[d] = (g + 1) % n;
            w = int'(din[g*8 +: 8]);
            dest = w >> (8 - chw);
            if (dest < n) begin
                mpush[d] = 1 << dest; merr[d] = 0; mdata[d] = w;
            end else begin
                mpush[d] = 0; merr[d] = 1;
            end
        end else begin
            mpush[d] = 0; merr[d] = 0;
        end
    endtask

    task automatic tick();
        #1;
        model_step(0, 4, rst4, mode4, int'(emp4), int'(af4), {96'b0, dat4},
                   32'(pop4), 32'(push4), 32'(dout4), 32'(err4));
        model_step(1, 3, rst3, mode3, int'(emp3), int'(af3), {104'b0, dat3},
                   32'(pop3), 32'(push3), 32'(dout3), 32'(err3));
        @(negedge clk);
    endtask

    task automatic pulse_reset4();
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0;
    endtask

    initial begin
        logic [3:0] rr_all[5];
        logic [3:0] rr_sparse[3];
        rr_all    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_sparse = '{4'b0001, 4'b0100, 4'b0001};
        for (int d = 0; d < 2; d++) begin
            mptr[d] = 0; mpush[d] = 0; merr[d] = 0; mdata[d] = 0;
        end
        rst4 = 1'b1; mode4 = 1'b0; emp4 = 4'hF; af4 = '0; dat4 = '0;
        rst3 = 1'b1; mode3 = 1'b0; emp3 = 3'h7; af3 = '0; dat3 = '0;
        @(negedge clk);

        // reset held with requests present
        emp4 = 4'b0000;
        dat4 = {8'h00, 8'h00, 8'h00, 8'h81};
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("reset pop", 32'(pop4), 0);
            chk("reset push", 32'(push4), 0);
            chk("reset data_out", 32'(dout4), 0);
            tick();
        end
        rst4 = 1'b0;

        // fixed priority, dest = 2
        #1 chk("fixed first pop", 32'(pop4), 32'h1);
        tick();
        #1 chk("fixed push dest2", 32'(push4), 32'h4);
        chk("fixed data_out", 32'(dout4), 32'h81);
        chk("fixed pop repeat", 32'(pop4), 32'h1);
        tick();
        tick();

        // round-robin, all requesting then sparse
        pulse_reset4();
        mode4 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 chk($sformatf("rr all step%0d", i), 32'(pop4), 32'(rr_all[i]));
            tick();
        end
        pulse_reset4();
        emp4 = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("rr sparse step%0d", i), 32'(pop4), 32'(rr_sparse[i]));
            tick();
        end

        // backpressure
        pulse_reset4();
        emp4 = 4'b0000;
        dat4 = {8'hC3, 8'h82, 8'h41, 8'h00};
        tick();
        tick();
        af4 = 4'b1000;
        #1 chk("stall pop", 32'(pop4), 0);
        chk("stall inflight push", 32'(push4), 32'h2);
        chk("stall inflight data", 32'(dout4), 32'h41);
        tick();
        tick();
        af4 = 4'b0000;
        #1 chk("resume pop", 32'(pop4), 32'h4);
        tick();

        // reset mid-flight
        pulse_reset4();
        emp4 = 4'b1101;
        #1 chk("midflight pop1", 32'(pop4), 32'h2);
        tick();
        rst4 = 1'b1;
        #1 chk("midflight reset pop", 32'(pop4), 0);
        tick();
        rst4 = 1'b0;
        emp4 = 4'b0000;
        #1 chk("midflight dropped push", 32'(push4), 0);
        chk("midflight ptr restart", 32'(pop4), 32'h1);
        tick();

        // randomized traffic on the 4-channel instance
        for (int i = 0; i < 400; i++) begin
            rst4  = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 9) == 0) mode4 = 1'($urandom);
            emp4  = 4'($urandom);
            af4   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            dat4  = $urandom;
            tick();
        end
        rst4 = 1'b1;

        // bad destination on the 3-channel instance
        rst3 = 1'b0; mode3 = 1'b0; emp3 = 3'b110; dat3 = {16'h0, 8'hC5};
        #1 chk("n3 bad pop", 32'(pop3), 32'h1);
        tick();
        dat3 = {16'h0, 8'h45};
        #1 chk("n3 bad push", 32'(push3), 0);
        chk("n3 bad err", 32'(err3), 32'h1);
        tick();
        #1 chk("n3 good push", 32'(push3), 32'h2);
        chk("n3 good data", 32'(dout3), 32'h45);
        chk("n3 good err", 32'(err3), 0);
        tick();

        for (int i = 0; i < 400; i++) begin
            rst3  = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 9) == 0) mode3 = 1'($urandom);
            emp3  = 3'($urandom);
            af3   = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b0;
            dat3  = 24'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
